// File: rtl/sd_adc_capture_ctrl.sv
// sd_adc_capture_ctrl: sigma-delta ADC burst sequencer with warm-up discard and FWFT sample FIFO
module sd_adc_capture_ctrl #(
    parameter int ADC_BITLEN     = 16,
    parameter int SETTLE_SAMPLES = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int LEN_BITS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic [LEN_BITS-1:0]   cmd_len,
    output logic                  adc_rst,
    input  logic [ADC_BITLEN-1:0] adc_data,
    input  logic                  adc_valid,
    output logic [ADC_BITLEN-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  overflow,
    output logic                  done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE_SAMPLES + 2);
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DRAIN} state_t;
    state_t state, state_n;
    logic [LEN_BITS-1:0] len_q, cap_cnt, cap_nxt;
    logic [SW-1:0] settle_cnt;
    logic [ADC_BITLEN:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic push_req, push_last, push, pop, start, finish;
    assign cap_nxt = cap_cnt + LEN_BITS'(1);
    assign start = state == IDLE && cmd_start;
    assign m_valid = count != '0;
    assign pop = m_valid && m_ready;
    assign push = push_req && (count < CW'(FIFO_DEPTH) || pop);
    assign m_data = m_valid ? mem[rd_ptr][ADC_BITLEN-1:0] : '0;
    assign m_last = m_valid && mem[rd_ptr][ADC_BITLEN];
    always_comb begin
        state_n = state;
        push_req = 1'b0;
        push_last = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE: if (cmd_start) state_n = SETTLE_SAMPLES == 0 ? CAPTURE : SETTLE;
            SETTLE: begin
                if (cmd_stop) begin
                    state_n = IDLE;
                    finish = 1'b1;
                end else if (adc_valid && settle_cnt == SW'(SETTLE_SAMPLES - 1)) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cmd_stop) begin
                    state_n = DRAIN;
                end else if (adc_valid) begin
                    push_req = 1'b1;
                    push_last = len_q != '0 && cap_nxt == len_q;
                    state_n = push_last ? DRAIN : CAPTURE;
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    state_n = IDLE;
                    finish = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            len_q <= '0;
            cap_cnt <= '0;
            settle_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            adc_rst <= 1'b1;
            busy <= 1'b0;
            overflow <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            adc_rst <= state_n == IDLE || state_n == DRAIN;
            busy <= state_n != IDLE;
            done <= finish;
            overflow <= start ? 1'b0 : overflow | (push_req && !push);
            if (start) begin
                len_q <= cmd_len;
                cap_cnt <= '0;
                settle_cnt <= '0;
            end else begin
                if (state == SETTLE && adc_valid) settle_cnt <= settle_cnt + SW'(1);
                if (push_req) cap_cnt <= cap_nxt;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_last, adc_data};
    end
endmodule

// File: tb/tb_sd_adc_capture_ctrl.sv
// tb_sd_adc_capture_ctrl: directed burst scenarios plus random traffic against a queue-level model
module tb_sd_adc_capture_ctrl;
    localparam int W = 16;
    localparam int SET = 4;
    localparam int DEPTH = 8;
    localparam int LB = 16;
    logic clk = 1'b0, rst = 1'b1, cmd_start = 1'b0, cmd_stop = 1'b0, adc_valid = 1'b0, m_ready = 1'b0;
    logic [LB-1:0] cmd_len = '0;
    logic [W-1:0] adc_data = '0;
    logic adc_rst, m_valid, m_last, busy, overflow, done;
    logic [W-1:0] m_data;
    int errs = 0, checks = 0, done_cnt = 0;
    logic [W:0] q[$];
    logic [W:0] got[$];
    bit act = 0, drn = 0, ovf_m = 0, done_m = 0, armed = 0, pop_m = 0, lst = 0;
    int sl = 0, cn = 0, ln = 0;

    sd_adc_capture_ctrl #(.ADC_BITLEN(W), .SETTLE_SAMPLES(SET), .FIFO_DEPTH(DEPTH), .LEN_BITS(LB)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_len(cmd_len),
        .adc_rst(adc_rst), .adc_data(adc_data), .adc_valid(adc_valid), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
        end
    endtask

    task automatic step(input logic s, input logic st, input logic v, input logic r, input logic [W-1:0] d);
        cmd_start = s;
        cmd_stop = st;
        adc_valid = v;
        m_ready = r;
        adc_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(0, 0, 0, r, '0);
    endtask

    // Burst-level model: a queue of {last,data}, a settle countdown and a sample count
    always @(posedge clk) begin
        armed = 1;
        if (rst) begin
            q.delete();
            act = 0;
            drn = 0;
            ovf_m = 0;
            done_m = 0;
        end else begin
            pop_m = q.size() > 0 && m_ready;
            done_m = 0;
            if (!act) begin
                if (cmd_start) begin
                    act = 1; drn = 0; sl = SET; cn = 0; ln = int'(cmd_len); ovf_m = 0;
                end
            end else if (drn) begin
                if (q.size() == 0) begin
                    act = 0; drn = 0; done_m = 1;
                end
            end else if (sl > 0) begin
                if (cmd_stop) begin
                    act = 0; done_m = 1;
                end else if (adc_valid) sl--;
            end else if (cmd_stop) begin
                drn = 1;
            end else if (adc_valid) begin
                cn++;
                lst = ln != 0 && cn == ln;
                if (q.size() < DEPTH || pop_m) q.push_back({lst, adc_data});
                else ovf_m = 1;
                if (lst) drn = 1;
            end
            if (pop_m) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("m_data", 32'(m_data), 32'(q[0][W-1:0]));
                chk("m_last", 32'(m_last), 32'(q[0][W]));
            end
            chk("adc_rst", 32'(adc_rst), 32'(!act || drn));
            chk("busy", 32'(busy), 32'(act));
            chk("overflow", 32'(overflow), 32'(ovf_m));
            chk("done", 32'(done), 32'(done_m));
            if (m_valid && m_ready) got.push_back({m_last, m_data});
            if (done) done_cnt++;
        end
    end

    initial begin
        idle(3, 0);
        rst = 0;
        chk("reset_adc_rst", 32'(adc_rst), 32'd1);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        // Test 1: 4 warm-up samples discarded, 5 captured with last on final one
        got.delete(); done_cnt = 0;
        cmd_len = 5;
        step(1, 0, 0, 1, '0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 1, W'(16'h000C + i));
        idle(15, 1);
        chk("t1_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t1_sample", 32'(got[i]), 32'({i == 4, W'(16'h0010 + i)}));
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_adc_rst", 32'(adc_rst), 32'd1);
        // Test 2: len 12 with consumer stalled, 4 dropped, then drain
        got.delete(); done_cnt = 0;
        cmd_len = 12;
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'hAAAA);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, W'(16'h0100 + i));
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_busy", 32'(busy), 32'd1);
        idle(20, 1);
        chk("t2_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("t2_sample", 32'(got[i]), 32'(W'(16'h0100 + i)));
        chk("t2_done", 32'(done_cnt), 32'd1);
        // Test 3: continuous, stop coincides with 21st sample; start clears old overflow
        got.delete(); done_cnt = 0;
        cmd_len = 0;
        step(1, 0, 0, 1, '0);
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 16'h5555);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, W'(16'h0200 + i));
        step(0, 1, 1, 1, 16'h0214);
        idle(10, 1);
        chk("t3_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < 20 && i < got.size(); i++) chk("t3_sample", 32'(got[i]), 32'(W'(16'h0200 + i)));
        chk("t3_done", 32'(done_cnt), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        // Test 4: start during capture ignored, burst still ends after 3
        got.delete(); done_cnt = 0;
        cmd_len = 3;
        step(1, 0, 0, 1, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 16'h0);
        step(0, 0, 1, 1, 16'h0300);
        cmd_len = 7;
        step(1, 0, 0, 1, '0);
        step(0, 0, 1, 1, 16'h0301);
        step(0, 0, 1, 1, 16'h0302);
        idle(10, 1);
        chk("t4_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) chk("t4_last", 32'(got[2]), 32'({1'b1, 16'h0302}));
        chk("t4_done", 32'(done_cnt), 32'd1);
        // Test 5: reset mid-capture with 3 queued
        got.delete(); done_cnt = 0;
        cmd_len = 10;
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, W'(16'h0400 + i));
        chk("t5_pre_valid", 32'(m_valid), 32'd1);
        rst = 1;
        step(0, 0, 0, 0, '0);
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_adc_rst", 32'(adc_rst), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        rst = 0;
        idle(10, 1);
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        // Test 6: push and pop on a full FIFO in the same cycle
        got.delete(); done_cnt = 0;
        cmd_len = 0;
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, W'(16'h0500 + i));
        step(0, 0, 1, 1, 16'h0508);
        chk("t6_overflow", 32'(overflow), 32'd0);
        step(0, 1, 0, 1, '0);
        idle(20, 1);
        chk("t6_count", 32'(got.size()), 32'd9);
        for (int i = 0; i < 9 && i < got.size(); i++) chk("t6_sample", 32'(got[i]), 32'(W'(16'h0500 + i)));
        chk("t6_overflow_end", 32'(overflow), 32'd0);
        // Random traffic, checked every cycle by the model
        rst = 1;
        idle(2, 0);
        rst = 0;
        for (int i = 0; i < 3000; i++) begin
            cmd_len = LB'($urandom_range(0, 12));
            step($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7, W'($urandom));
        end
        idle(30, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
